// File: rtl/FIFO_Shared_pkg.sv
// FIFO_Shared_pkg: default widths and FSM state encoding shared by the FIFO write arbiter.
package FIFO_Shared_pkg;
  localparam int FIFO_WIDTH = 16;
  localparam int NUM_REQ = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, BACKOFF} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, search starts at ptr and wraps.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    // Walk from the farthest offset down so the requester nearest ptr wins last.
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        gnt = N'(1) << ((int'(ptr) + k) % N);
        idx = IW'((int'(ptr) + k) % N);
      end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin merge of NUM_REQ producers onto one FIFO write port,
// holding each accepted word until the FIFO acknowledges it and retrying on overflow.
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = FIFO_Shared_pkg::FIFO_WIDTH,
  parameter int NUM_REQ = FIFO_Shared_pkg::NUM_REQ,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  output logic [7:0]                    retry_cnt
);
  import FIFO_Shared_pkg::*;
  state_t state, state_nxt;
  logic [FIFO_WIDTH-1:0] hold;
  logic [IW-1:0] ptr, win;
  logic [NUM_REQ-1:0] gnt;
  logic accept;
  rr_arbiter #(.N(NUM_REQ)) u_rr (.req(req_valid), .ptr(ptr), .gnt(gnt), .idx(win));
  // Ready is masked during reset so no producer sees a handshake that gets discarded.
  assign accept = state == IDLE && !fifo_full && |req_valid && !rst;
  assign req_ready = accept ? gnt : '0;
  assign fifo_wr_en = state == ISSUE;
  assign fifo_data_in = hold;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = accept ? ISSUE : IDLE;
      ISSUE:   state_nxt = CHECK;
      CHECK:   state_nxt = fifo_wr_ack ? IDLE : BACKOFF;
      BACKOFF: state_nxt = fifo_full ? BACKOFF : ISSUE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      hold <= '0;
      ptr <= '0;
      grant_id <= '0;
      retry_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        hold <= req_data[win*FIFO_WIDTH +: FIFO_WIDTH];
        grant_id <= win;
        ptr <= win == IW'(NUM_REQ - 1) ? '0 : win + 1'b1;
      end
      // A missing ack counts as a failed write, overflow flag or not.
      if (state == CHECK && !fifo_wr_ack && retry_cnt != 8'hFF)
        retry_cnt <= retry_cnt + 1'b1;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, data width of each requester and of the FIFO write port.
REQ-002 Parameter NUM_REQ, default 4, number of producers; legal 2..8.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, all state on posedge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req_valid  in  NUM_REQ  per-requester write request; held with data until accepted.
REQ-007 req_data  in  NUM_REQ*FIFO_WIDTH  packed request data; requester i occupies slice [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 req_ready  out  NUM_REQ  one-hot acceptance pulse.
REQ-009 fifo_data_in  out  FIFO_WIDTH  data to the FIFO write port.
REQ-010 fifo_wr_en  out  1  FIFO write strobe.
REQ-011 fifo_full  in  1  FIFO full flag.
REQ-012 fifo_wr_ack  in  1  FIFO write acknowledge, registered, one cycle after wr_en.
REQ-013 fifo_overflow  in  1  FIFO overflow, registered, one cycle after wr_en.
REQ-014 grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 retry_cnt  out  8  saturating count of overflow retries.

Function
REQ-017 FSM states: IDLE, ISSUE, CHECK, BACKOFF.
REQ-018 IDLE: if !fifo_full and any req_valid, the round-robin winner is accepted: req_ready[winner]=1 combinationally that cycle, req_data slice latched into the hold register, grant_id<=winner, next state ISSUE; otherwise stay IDLE with req_ready all zero.
REQ-019 Round-robin: search starts at (last grant + 1) mod NUM_REQ; the pointer advances only on acceptance.
REQ-020 ISSUE: fifo_wr_en=1 for exactly one cycle, fifo_data_in=hold register; next state CHECK.
REQ-021 CHECK: fifo_wr_en=0; fifo_wr_ack=1 -> IDLE; fifo_overflow=1, or neither flag set -> retry_cnt increments, next state BACKOFF.
REQ-022 BACKOFF: wait while fifo_full=1; when fifo_full=0 -> ISSUE with the same hold data.
REQ-023 Data integrity: each accepted word is written exactly once and in acceptance order; no word is dropped or duplicated.
REQ-024 At most one req_ready bit is high per cycle, and only in IDLE.
REQ-025 fifo_data_in is driven from the hold register at all times, never directly from req_data.
REQ-026 retry_cnt saturates at 255 and does not wrap.
REQ-027 Throughput: one word per 3 cycles without retries.

Reset
REQ-028 On rst: state=IDLE, RR pointer selects requester 0 first, hold register=0, fifo_wr_en=0, grant_id=0, retry_cnt=0, busy=0, req_ready=0.
REQ-029 Reset during ISSUE, CHECK or BACKOFF aborts the operation: the latched word is discarded and no wr_en is issued after reset.

Structure
REQ-030 FIFO_WIDTH, NUM_REQ and the FSM state enum typedef reside in FIFO_Shared_pkg.
REQ-031 The design has one sub-module, rr_arbiter: a combinational round-robin picker with inputs req[NUM_REQ] and ptr, and outputs one-hot gnt and its index.

Verification
REQ-032 Only req_valid[1] set, data 0xA5A5: req_ready[1] pulses at cycle 0, wr_en=1 with data 0xA5A5 at cycle 1, wr_ack at cycle 2, IDLE at cycle 3, grant_id=1.
REQ-033 All four req_valid held from reset: acceptance order 0,1,2,3,0; each req_ready pulses once per 3 cycles.
REQ-034 fifo_full=1 with requests pending: no req_ready and no wr_en; fifo_full falls -> acceptance in that cycle.
REQ-035 fifo_overflow=1 in CHECK with fifo_full=1 for 4 cycles: BACKOFF, retry_cnt=1, same data rewritten once full falls.
REQ-036 rst asserted in BACKOFF: all outputs at reset values, the next acceptance starts at requester 0, and the old word is never written.
REQ-037 300 forced overflows: retry_cnt holds at 255.
